// File: rtl/async_pipe_rx.sv
`default_nettype none
// ============================================================================
// Module      : async_pipe_rx
// Description : Clocked receive endpoint for a 4-phase bundled-data req/ack
//               pipeline. It synchronises req_in, captures data_in into a
//               small FIFO, returns ack_out, and presents tokens on a
//               valid/ready interface. Backpressure withholds ack_out.
// Options     : ASYNC_PIPE_RX_STAT_EN adds the tok_cnt and stall_flag outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module async_pipe_rx #(
  parameter int DW          = 3,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,          // asynchronous, active-low
  input  logic          req_in,
  input  logic [DW-1:0] data_in,
  output logic          ack_out,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready
`ifdef ASYNC_PIPE_RX_STAT_EN
  ,
  output logic [7:0]    tok_cnt,
  output logic          stall_flag
`endif
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   req_s;
  state_t                 state_q, state_d;
  logic                   ack_q, ack_d;
  logic [DW-1:0]          mem_q [DEPTH];
  logic [DW-1:0]          mem_d [DEPTH];
  logic [c_AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [c_AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [c_CW-1:0]        count_q, count_d;
  logic                   full;
  logic                   push;
  logic                   pop;

  // req_in shift chain; req_s is the last flop of the synchroniser
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], req_in};
  end

  assign req_s      = sync_q[SYNC_STAGES-1];
  // Full uses only the registered count, so a pop never enables a push in
  // the same cycle.
  assign full       = (count_q == c_CW'(DEPTH));
  assign dout_valid = (count_q != '0);
  assign pop        = dout_valid & dout_ready;
  assign dout       = dout_valid ? mem_q[rd_ptr_q] : '0;
  assign ack_out    = ack_q;

  // Handshake FSM: one FIFO write per 4-phase cycle, only from IDLE
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_s && !full) begin
          push    = 1'b1;
          ack_d   = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        if (!req_s) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        ack_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // FIFO storage, pointers and occupancy count
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = data_in;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers with asynchronous flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q   <= '0;
      state_q  <= IDLE;
      ack_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      ack_q    <= ack_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

`ifdef ASYNC_PIPE_RX_STAT_EN
  logic [7:0] tok_cnt_q, tok_cnt_d;
  logic       stall_q, stall_d;

  // Saturating write counter and registered upstream-stall indicator
  always_comb begin
    tok_cnt_d = tok_cnt_q;
    if (push && (tok_cnt_q != 8'hFF)) begin
      tok_cnt_d = tok_cnt_q + 8'd1;
    end
    stall_d = (state_q == IDLE) && req_s && full;
  end

  // Statistics registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tok_cnt_q <= '0;
      stall_q   <= 1'b0;
    end else begin
      tok_cnt_q <= tok_cnt_d;
      stall_q   <= stall_d;
    end
  end

  assign tok_cnt    = tok_cnt_q;
  assign stall_flag = stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_async_pipe_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_async_pipe_rx
// Description : Directed self-checking bench for async_pipe_rx. Define
//               ASYNC_PIPE_RX_STAT_EN to also exercise tok_cnt/stall_flag.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_async_pipe_rx;

  logic       clk;
  logic       rst;
  logic       req_in;
  logic [2:0] data_in;
  logic       ack_out;
  logic [2:0] dout;
  logic       dout_valid;
  logic       dout_ready;
`ifdef ASYNC_PIPE_RX_STAT_EN
  logic [7:0] tok_cnt;
  logic       stall_flag;
`endif

  int errors = 0;
  int checks = 0;

  async_pipe_rx #(
    .DW          (3),
    .DEPTH       (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_in     (req_in),
    .data_in    (data_in),
    .ack_out    (ack_out),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
`ifdef ASYNC_PIPE_RX_STAT_EN
    ,
    .tok_cnt    (tok_cnt),
    .stall_flag (stall_flag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one clock edge, then settle 1 time unit past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // full 4-phase handshake with bounded waits on ack_out
  task automatic send(input logic [2:0] d);
    int n;
    data_in = d;
    req_in  = 1'b1;
    n = 0;
    while (ack_out !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    chk("send_ack_rise", {31'd0, ack_out}, 32'd1);
    req_in = 1'b0;
    n = 0;
    while (ack_out !== 1'b0 && n < 30) begin
      tick();
      n++;
    end
    chk("send_ack_fall", {31'd0, ack_out}, 32'd0);
  endtask

  initial begin
    int n;
    logic [2:0] drain [4];
    rst        = 1'b0;
    req_in     = 1'b0;
    data_in    = 3'd0;
    dout_ready = 1'b0;
    #2;
    // ---- reset state
    chk("rst_ack",   {31'd0, ack_out},    32'd0);
    chk("rst_valid", {31'd0, dout_valid}, 32'd0);
    chk("rst_dout",  {29'd0, dout},       32'd0);
    chk("rst_count", {29'd0, dut.count_q}, 32'd0);
`ifdef ASYNC_PIPE_RX_STAT_EN
    chk("rst_tokcnt", {24'd0, tok_cnt}, 32'd0);
    chk("rst_stall",  {31'd0, stall_flag}, 32'd0);
`endif
    tick();
    tick();
    rst = 1'b1;
    tick();

    // ---- single token, latency SYNC_STAGES+1
    dout_ready = 1'b1;
    data_in    = 3'b101;
    req_in     = 1'b1;
    tick();
    tick();
    chk("s1_ack_before", {31'd0, ack_out}, 32'd0);
    tick();
    chk("s1_ack_edge3",  {31'd0, ack_out},    32'd1);
    chk("s1_valid",      {31'd0, dout_valid}, 32'd1);
    chk("s1_dout",       {29'd0, dout},       32'd5);
    req_in = 1'b0;
    tick();
    chk("s1_popped",     {31'd0, dout_valid}, 32'd0);
    tick();
    chk("s1_ack_hold",   {31'd0, ack_out}, 32'd1);
    tick();
    chk("s1_ack_fall3",  {31'd0, ack_out}, 32'd0);

    // ---- burst of 4 with backpressure, 5th token stalled
    dout_ready = 1'b0;
    send(3'd1);
    send(3'd2);
    send(3'd3);
    send(3'd4);
    chk("s2_count4", {29'd0, dut.count_q}, 32'd4);
    chk("s2_head",   {29'd0, dout},        32'd1);
    data_in = 3'd7;
    req_in  = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("s2_full_noack", {31'd0, ack_out}, 32'd0);
`ifdef ASYNC_PIPE_RX_STAT_EN
    chk("s2_stall_hi", {31'd0, stall_flag}, 32'd1);
`endif
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    chk("s2_pop_head",  {29'd0, dout},    32'd2);
    chk("s2_same_edge", {31'd0, ack_out}, 32'd0);
`ifdef ASYNC_PIPE_RX_STAT_EN
    chk("s2_stall_still", {31'd0, stall_flag}, 32'd1);
`endif
    tick();
    chk("s2_ack5",   {31'd0, ack_out},     32'd1);
    chk("s2_count",  {29'd0, dut.count_q}, 32'd4);
`ifdef ASYNC_PIPE_RX_STAT_EN
    chk("s2_stall_lo", {31'd0, stall_flag}, 32'd0);
`endif
    req_in = 1'b0;
    n = 0;
    while (ack_out !== 1'b0 && n < 30) begin
      tick();
      n++;
    end
    chk("s2_ack5_fall", {31'd0, ack_out}, 32'd0);

    // ---- drain order across pointer wrap
    drain[0] = 3'd2;
    drain[1] = 3'd3;
    drain[2] = 3'd4;
    drain[3] = 3'd7;
    dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("s3_valid%0d", i), {31'd0, dout_valid}, 32'd1);
      chk($sformatf("s3_dout%0d", i),  {29'd0, dout},       {29'd0, drain[i]});
      tick();
    end
    chk("s3_empty", {31'd0, dout_valid}, 32'd0);
    chk("s3_dout0", {29'd0, dout},       32'd0);

    // ---- simultaneous push and pop at count=2
    dout_ready = 1'b0;
    send(3'd1);
    send(3'd2);
    chk("s4_count2", {29'd0, dut.count_q}, 32'd2);
    data_in = 3'd3;
    req_in  = 1'b1;
    tick();
    tick();
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    chk("s4_ack",    {31'd0, ack_out},     32'd1);
    chk("s4_count",  {29'd0, dut.count_q}, 32'd2);
    chk("s4_head",   {29'd0, dout},        32'd2);
    req_in = 1'b0;
    n = 0;
    while (ack_out !== 1'b0 && n < 30) begin
      tick();
      n++;
    end
    chk("s4_ack_fall", {31'd0, ack_out}, 32'd0);
    dout_ready = 1'b1;
    tick();
    chk("s4_next", {29'd0, dout}, 32'd3);
    tick();
    chk("s4_empty", {31'd0, dout_valid}, 32'd0);

    // ---- reset mid-handshake, token recaptured once
    dout_ready = 1'b0;
    data_in    = 3'd6;
    req_in     = 1'b1;
    tick();
    tick();
    tick();
    chk("s5_ack_pre", {31'd0, ack_out}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("s5_async_ack",   {31'd0, ack_out},    32'd0);
    chk("s5_async_valid", {31'd0, dout_valid}, 32'd0);
    chk("s5_async_dout",  {29'd0, dout},       32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    tick();
    chk("s5_sync_wait", {31'd0, ack_out}, 32'd0);
    tick();
    chk("s5_reack", {31'd0, ack_out}, 32'd1);
    chk("s5_dout",  {29'd0, dout},    32'd6);
    for (int i = 0; i < 4; i++) tick();
    chk("s5_once", {29'd0, dut.count_q}, 32'd1);
    req_in = 1'b0;
    n = 0;
    while (ack_out !== 1'b0 && n < 30) begin
      tick();
      n++;
    end
    chk("s5_ack_fall", {31'd0, ack_out},     32'd0);
    chk("s5_count",    {29'd0, dut.count_q}, 32'd1);
    dout_ready = 1'b1;
    tick();
    chk("s5_drained", {31'd0, dout_valid}, 32'd0);

`ifdef ASYNC_PIPE_RX_STAT_EN
    // ---- statistics: saturation and stall indicator
    for (int i = 0; i < 300; i++) send(3'(i));
    tick();
    chk("st_tokcnt_sat", {24'd0, tok_cnt}, 32'd255);
    dout_ready = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) send(3'(i));
    data_in = 3'd5;
    req_in  = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("st_stall_full", {31'd0, stall_flag}, 32'd1);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    chk("st_stall_popedge", {31'd0, stall_flag}, 32'd1);
    tick();
    chk("st_stall_clear", {31'd0, stall_flag}, 32'd0);
    chk("st_tokcnt_hold", {24'd0, tok_cnt},    32'd255);
    req_in = 1'b0;
    n = 0;
    while (ack_out !== 1'b0 && n < 30) begin
      tick();
      n++;
    end
    chk("st_ack_fall", {31'd0, ack_out}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/async_pipe_rx.md
Name: async_pipe_rx

Overview:
- Clocked receiving endpoint for the asynchronous req/ack bundled-data pipeline; sits at the output of a stage chain.
- Synchronises req_in, captures data_in into a small FIFO and returns ack_out using the 4-phase (return-to-zero) protocol.
- Presents tokens to synchronous logic on a valid/ready interface; backpressure stalls ack, which stalls the pipeline.

Parameters:
- DW, 3, token data width in bits.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- SYNC_STAGES, 2, flops in the req_in synchroniser; minimum 2.

Ports:
- clk  input  1  receive-domain clock.
- rst  input  1  asynchronous, active-low reset.
- req_in  input  1  request from the last pipeline stage (asynchronous).
- data_in  input  DW  bundled data; stable from req_in rise until ack_out rise.
- ack_out  output  1  acknowledge to the last pipeline stage.
- dout  output  DW  FIFO head token.
- dout_valid  output  1  FIFO non-empty.
- dout_ready  input  1  consumer accepts dout this cycle.

Behaviour:
- Reset (rst=0, asynchronous): ack_out=0, dout_valid=0, dout=0, FIFO pointers and count=0, synchroniser flops=0, FSM=IDLE.
- req_in passes through SYNC_STAGES flops to produce req_s. data_in is never synchronised; it is sampled only when req_s=1, which is safe under bundled-data timing.
- FSM has two states:
  - IDLE: when req_s=1 and count<DEPTH, write data_in into FIFO, set ack_out to 1, go to ACK. When req_s=1 and count==DEPTH, stay in IDLE with ack_out=0; the token is held upstream.
  - ACK: hold ack_out=1. When req_s=0, set ack_out to 0 and go to IDLE.
- Exactly one FIFO write per 4-phase cycle. No write ever occurs in ACK.
- Latency:
  - req_in rise to ack_out rise: SYNC_STAGES+1 clk edges, with an empty FIFO.
  - ack_out and dout_valid rise on the same edge.
  - req_in fall to ack_out fall: SYNC_STAGES+1 edges.
- FIFO:
  - Pop occurs when dout_valid & dout_ready.
  - dout = mem[rd_ptr], combinational from the registered array and pointer. dout is 0 when empty.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full decision uses the registered count only. A pop in the same cycle does not enable a push; the push occurs on the following cycle.
- Pop when empty: ignored, no pointer change.
- dout_ready may toggle freely. dout and dout_valid hold until popped.
- Reset asserted mid-handshake: ack_out drops immediately and the FIFO is flushed. If req_in is still high after reset release, the token is accepted again. The upstream pipeline shares rst, so this is the intended recovery.
- Protocol violation (req_in falls before ack_out rises): the token is lost. The FSM stays in IDLE and no write occurs.

Optional Feature:
- Macro: ASYNC_PIPE_RX_STAT_EN.
- When defined, two extra outputs are present:
  - tok_cnt (8 bits): saturating count of FIFO writes. It holds at 255 and resets to 0.
  - stall_flag (1 bit): registered, high in every cycle where the FSM is in IDLE with req_s=1 and count==DEPTH.
- When undefined: neither port nor its logic exists. Core behaviour and timing are identical in both builds.

Test Plan:
- Single token, SYNC_STAGES=2, dout_ready=1: drive data_in=3'b101, then req_in rise. Required: ack_out rises at edge 3 with dout_valid=1 and dout=5. Drop req_in; ack_out falls at edge 3 after that.
- Burst of 4 tokens (1,2,3,4), dout_ready=0: all 4 acked and count=4. 5th token (7): req held, ack_out stays 0. Pulse dout_ready for 1 cycle: dout=1 is popped, and the 5th token is acked on the next edge after count drops.
- Drain order: after the previous scenario, hold dout_ready=1. Required sequence on dout: 2, 3, 4, 7; dout_valid falls after 7. Pointers wrap with no lost or duplicated token.
- Simultaneous push/pop with count=2: push and pop land on the same edge. count stays 2 and the head advances correctly.
- Reset mid-handshake: assert rst=0 while ack_out=1 and req_in=1. ack_out and dout_valid go 0 asynchronously. After release with req_in still 1, the token is re-captured once.
- STAT build (ASYNC_PIPE_RX_STAT_EN defined): push 300 tokens with dout_ready=1, then tok_cnt=255. With a full FIFO and req held, stall_flag=1; it returns to 0 one edge after space frees.
